// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA encrypt/decrypt datapath: default width,
// encryptor FSM encoding and the op-select codes for the shared modular multiplier.
package rsa_pkg;

  localparam int RSA_WIDTH = 64;

  typedef enum logic [2:0] {
    IDLE,
    REDUCE,
    MULT,
    SQUARE,
    DONE
  } enc_state_t;

  typedef logic [1:0] op_sel_t;

  localparam op_sel_t OP_REDUCE = 2'd0;
  localparam op_sel_t OP_MULT   = 2'd1;
  localparam op_sel_t OP_SQUARE = 2'd2;

endpackage

// File: rtl/rsa_modmul.sv
// Bit-serial interleaved modular multiplier: p = (a * b) mod n, MSB-first over a.
// Latency WIDTH+2 cycles from start_i (load, WIDTH iterations, done_o with result).
module rsa_modmul
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] n_i,
  output logic             done_o,
  output logic [WIDTH-1:0] p_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int AW = WIDTH + 2;

  // One iteration: P <- 2P + a_bit*B, reduced after the doubling and after the
  // add so that P stays strictly below n for any b < n.
  function automatic logic [AW-1:0] mm_step(input logic [AW-1:0]    p,
                                            input logic             abit,
                                            input logic [WIDTH-1:0] b,
                                            input logic [WIDTH-1:0] n);
    logic [AW-1:0] t;
    logic [AW-1:0] nx;
    nx = {2'b00, n};
    t  = p << 1;
    if (t >= nx) t = t - nx;
    if (abit) t = t + {2'b00, b};
    if (t >= nx) t = t - nx;
    return t;
  endfunction

  logic             busy_q;
  logic             done_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] n_q;
  logic [AW-1:0]    p_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        busy_q <= 1'b1;
        cnt_q  <= '0;
      end else if (busy_q) begin
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start_i) begin
      a_q <= a_i;
      b_q <= b_i;
      n_q <= n_i;
      p_q <= '0;
    end else if (busy_q) begin
      p_q <= mm_step(p_q, a_q[WIDTH-1], b_q, n_q);
      a_q <= a_q << 1;
    end
  end

  assign done_o = done_q;
  assign p_o    = p_q[WIDTH-1:0];

endmodule

// File: rtl/rsa_encryptor.sv
// RSA encryptor: C = M^e mod n by right-to-left square-and-multiply over one modmul.
// Optional RSA_ENC_CYCLE_COUNT_EN adds the last_cycles busy-cycle counter output.
module rsa_encryptor
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic [WIDTH-1:0] n_in,
  input  logic [WIDTH-1:0] e_in,
  input  logic             msg_valid,
  input  logic [WIDTH-1:0] msg_in,
  output logic             msg_ready,
  output logic [WIDTH-1:0] encrypted_message,
  output logic             msg_received_sig,
  output logic             key_loaded,
  output logic             key_dropped,
`ifdef RSA_ENC_CYCLE_COUNT_EN
  output logic [CNT_W-1:0] last_cycles,
`endif
  output logic             mod_err
);

  enc_state_t       state_q;
  op_sel_t          op_q;
  logic             start_q;
  logic             sig_q;
  logic             key_loaded_q;
  logic             key_dropped_q;
  logic             mod_err_q;
  logic [WIDTH-1:0] n_q;
  logic [WIDTH-1:0] e_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] exp_q;
  logic [WIDTH-1:0] base_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] enc_q;

  logic             xfer_d;
  logic [WIDTH-1:0] n_cur_d;
  logic [WIDTH-1:0] e_cur_d;
  logic [WIDTH-1:0] exp_sh_d;
  logic [WIDTH-1:0] mm_a_d;
  logic [WIDTH-1:0] mm_b_d;
  logic [WIDTH-1:0] mm_p;
  logic             mm_done;

  assign msg_ready = (state_q == IDLE) & key_loaded_q;
  assign xfer_d    = msg_valid & msg_ready;
  // A key arriving in the same cycle as a transfer applies to that transfer.
  assign n_cur_d   = key_valid ? n_in : n_q;
  assign e_cur_d   = key_valid ? e_in : e_q;
  assign exp_sh_d  = exp_q >> 1;

  always_comb begin
    mm_a_d = m_q;
    mm_b_d = WIDTH'(1);
    case (op_q)
      OP_MULT: begin
        mm_a_d = result_q;
        mm_b_d = base_q;
      end
      OP_SQUARE: begin
        mm_a_d = base_q;
        mm_b_d = base_q;
      end
      default: ;
    endcase
  end

  rsa_modmul #(.WIDTH(WIDTH)) u_modmul (
    .clk    (clk),
    .rst    (rst),
    .start_i(start_q),
    .a_i    (mm_a_d),
    .b_i    (mm_b_d),
    .n_i    (n_q),
    .done_o (mm_done),
    .p_o    (mm_p)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      op_q          <= OP_REDUCE;
      start_q       <= 1'b0;
      sig_q         <= 1'b0;
      key_loaded_q  <= 1'b0;
      key_dropped_q <= 1'b0;
      mod_err_q     <= 1'b0;
      n_q           <= '0;
      e_q           <= '0;
      m_q           <= '0;
      exp_q         <= '0;
      base_q        <= '0;
      result_q      <= '0;
      enc_q         <= '0;
    end else begin
      start_q <= 1'b0;
      sig_q   <= 1'b0;
      if (key_valid && state_q != IDLE) key_dropped_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (key_valid) begin
            n_q          <= n_in;
            e_q          <= e_in;
            key_loaded_q <= 1'b1;
          end
          if (xfer_d) begin
            m_q   <= msg_in;
            exp_q <= e_cur_d;
            if (n_cur_d == '0) begin
              result_q  <= '0;
              mod_err_q <= 1'b1;
              state_q   <= DONE;
            end else begin
              op_q    <= OP_REDUCE;
              start_q <= 1'b1;
              state_q <= REDUCE;
            end
          end
        end
        REDUCE: begin
          if (mm_done) begin
            base_q   <= mm_p;
            result_q <= (n_q > WIDTH'(1)) ? WIDTH'(1) : '0;
            if (exp_q == '0) begin
              state_q <= DONE;
            end else if (exp_q[0]) begin
              op_q    <= OP_MULT;
              start_q <= 1'b1;
              state_q <= MULT;
            end else begin
              // Bit 0 is consumed here so exp_q[0] tracks the squared base's weight.
              exp_q   <= exp_sh_d;
              op_q    <= OP_SQUARE;
              start_q <= 1'b1;
              state_q <= SQUARE;
            end
          end
        end
        MULT: begin
          if (mm_done) begin
            result_q <= mm_p;
            exp_q    <= exp_sh_d;
            if (exp_sh_d == '0) begin
              state_q <= DONE;
            end else begin
              op_q    <= OP_SQUARE;
              start_q <= 1'b1;
              state_q <= SQUARE;
            end
          end
        end
        SQUARE: begin
          if (mm_done) begin
            base_q <= mm_p;
            if (exp_q[0]) begin
              op_q    <= OP_MULT;
              start_q <= 1'b1;
              state_q <= MULT;
            end else begin
              exp_q <= exp_sh_d;
              if (exp_sh_d == '0) begin
                state_q <= DONE;
              end else begin
                start_q <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          enc_q   <= result_q;
          sig_q   <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef RSA_ENC_CYCLE_COUNT_EN
  logic [CNT_W-1:0] cyc_q;
  logic [CNT_W-1:0] last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q  <= '0;
      last_q <= '0;
    end else begin
      if (xfer_d) begin
        cyc_q <= '0;
      end else if (state_q != IDLE && cyc_q != '1) begin
        cyc_q <= cyc_q + 1'b1;
      end
      if (state_q == DONE) last_q <= cyc_q;
    end
  end

  assign last_cycles = last_q;
`endif

  assign encrypted_message = enc_q;
  assign msg_received_sig  = sig_q;
  assign key_loaded        = key_loaded_q;
  assign key_dropped       = key_dropped_q;
  assign mod_err           = mod_err_q;

endmodule

// File: tb/tb_rsa_encryptor.sv
// Self-checking bench for rsa_encryptor: directed key/message cases plus random
// jobs compared against a plain-arithmetic modular exponentiation model.
module tb_rsa_encryptor;

  localparam int W  = 64;
  localparam int MM = W + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          key_valid;
  logic [W-1:0]  n_in;
  logic [W-1:0]  e_in;
  logic          msg_valid;
  logic [W-1:0]  msg_in;
  logic          msg_ready;
  logic [W-1:0]  encrypted_message;
  logic          msg_received_sig;
  logic          key_loaded;
  logic          key_dropped;
  logic          mod_err;
`ifdef RSA_ENC_CYCLE_COUNT_EN
  logic [31:0]   last_cycles;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rsa_encryptor dut (
    .clk              (clk),
    .rst              (rst),
    .key_valid        (key_valid),
    .n_in             (n_in),
    .e_in             (e_in),
    .msg_valid        (msg_valid),
    .msg_in           (msg_in),
    .msg_ready        (msg_ready),
    .encrypted_message(encrypted_message),
    .msg_received_sig (msg_received_sig),
    .key_loaded       (key_loaded),
    .key_dropped      (key_dropped),
`ifdef RSA_ENC_CYCLE_COUNT_EN
    .last_cycles      (last_cycles),
`endif
    .mod_err          (mod_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_pow(input logic [63:0] m, input logic [63:0] e,
                                          input logic [63:0] n);
    logic [127:0] r;
    logic [127:0] b;
    logic [127:0] nn;
    if (n == 0) return 64'd0;
    nn = {64'd0, n};
    r  = 128'd1 % nn;
    b  = {64'd0, m} % nn;
    for (int i = 0; i < 64; i++) begin
      if (e[i]) r = (r * b) % nn;
      b = (b * b) % nn;
    end
    return r[63:0];
  endfunction

  // Number of modular multiplications: one reduction, one multiply per set bit,
  // one squaring per bit position above the lowest.
  function automatic int ref_ops(input logic [63:0] e, input logic [63:0] n);
    int msb;
    if (n == 0) return 0;
    if (e == 0) return 1;
    msb = 0;
    for (int i = 0; i < 64; i++) if (e[i]) msb = i;
    return 1 + $countones(e) + msb;
  endfunction

  task automatic load_key(input logic [63:0] n, input logic [63:0] e);
    n_in      = n;
    e_in      = e;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    chk("key_loaded", key_loaded, 1);
  endtask

  // Called on a negedge. lat counts negedges after the transfer edge.
  task automatic run_msg(input logic [63:0] m, input int poke_at, input int rst_at,
                         output logic [63:0] got, output int lat, output bit done);
    int w;
    done      = 1'b0;
    lat       = 0;
    got       = '0;
    msg_in    = m;
    msg_valid = 1'b1;
    w = 0;
    while (!msg_ready && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (!msg_ready) begin
      chk("xfer_timeout", 0, 1);
      msg_valid = 1'b0;
      return;
    end
    while (lat < 5000 && !done) begin
      @(negedge clk);
      lat++;
      if (lat == 1) msg_valid = 1'b0;
      key_valid = (lat == poke_at);
      if (lat == poke_at) begin
        n_in = 64'd77;
        e_in = 64'd3;
      end
      if (lat == rst_at) begin
        key_valid = 1'b0;
        rst       = 1'b1;
        #1;
        return;
      end
      if (msg_received_sig) done = 1'b1;
    end
    key_valid = 1'b0;
    got       = encrypted_message;
  endtask

  task automatic do_job(input string tag, input logic [63:0] m, input logic [63:0] n,
                        input logic [63:0] e, input logic [63:0] exp_ct, input int poke_at);
    logic [63:0] got;
    int          lat;
    bit          done;
    run_msg(m, poke_at, 0, got, lat, done);
    chk({tag, "_done"}, 64'(done), 1);
    if (done) begin
      chk({tag, "_ct"}, got, exp_ct);
      chk({tag, "_lat"}, 64'(lat), 64'(ref_ops(e, n) * MM + 2));
      @(negedge clk);
      chk({tag, "_pw"}, msg_received_sig, 0);
    end
  endtask

  initial begin
    logic [63:0] rn, re, rm, got;
    int          lat, xfers, pulses;
    bit          done, seen;

    rst       = 1'b1;
    key_valid = 1'b0;
    n_in      = '0;
    e_in      = '0;
    msg_valid = 1'b0;
    msg_in    = '0;
    repeat (3) @(negedge clk);
    chk("rst_ct", encrypted_message, 0);
    chk("rst_sig", msg_received_sig, 0);
    chk("rst_kl", key_loaded, 0);
    chk("rst_kd", key_dropped, 0);
    chk("rst_me", mod_err, 0);
    chk("rst_rdy", msg_ready, 0);
    rst = 1'b0;
    @(negedge clk);

    msg_valid = 1'b1;
    msg_in    = 64'd65;
    seen      = 1'b0;
    pulses    = 0;
    repeat (20) begin
      @(negedge clk);
      seen   = seen | msg_ready;
      pulses = pulses + int'(msg_received_sig);
    end
    chk("nokey_rdy", 64'(seen), 0);
    chk("nokey_pulse", 64'(pulses), 0);

    load_key(64'd3233, 64'd17);
    do_job("m65", 64'd65, 64'd3233, 64'd17, 64'd2790, 0);

    // msg_valid held high: jobs must serialize, transfers at 0, 464, 928.
    msg_valid = 1'b1;
    msg_in    = 64'd65;
    xfers     = 0;
    pulses    = 0;
    for (int c = 0; c < 930; c++) begin
      xfers  = xfers + int'(msg_valid & msg_ready);
      pulses = pulses + int'(msg_received_sig);
      @(negedge clk);
    end
    msg_valid = 1'b0;
    chk("b2b_xfers", 64'(xfers), 3);
    chk("b2b_pulses", 64'(pulses), 2);
    seen = 1'b0;
    for (int w = 0; w < 600 && !seen; w++) begin
      @(negedge clk);
      seen = msg_received_sig;
    end
    chk("b2b_drain", 64'(seen), 1);
    chk("b2b_ct", encrypted_message, 64'd2790);
    @(negedge clk);

    load_key(64'd3233, 64'd1);
    do_job("e1", 64'd5000, 64'd3233, 64'd1, 64'd1767, 0);
    load_key(64'd3233, 64'd0);
    do_job("e0", 64'd123, 64'd3233, 64'd0, 64'd1, 0);
    load_key(64'd1, 64'd17);
    do_job("n1", 64'd9, 64'd1, 64'd17, 64'd0, 0);
    chk("n1_me", mod_err, 0);
    load_key(64'd0, 64'd5);
    do_job("n0", 64'd42, 64'd0, 64'd5, 64'd0, 0);
    chk("n0_me", mod_err, 1);

    load_key(64'd3233, 64'd17);
    chk("pre_kd", key_dropped, 0);
    do_job("drop", 64'd65, 64'd3233, 64'd17, 64'd2790, 100);
    chk("drop_kd", key_dropped, 1);
    do_job("oldkey", 64'd65, 64'd3233, 64'd17, 64'd2790, 0);

    for (int i = 0; i < 8; i++) begin
      rn = {$urandom, $urandom};
      if (rn < 2) rn = 64'd5;
      re = 64'($urandom_range(0, 4095));
      rm = {$urandom, $urandom};
      load_key(rn, re);
      do_job("rand", rm, rn, re, ref_pow(rm, re, rn), 0);
    end

    load_key(64'd3233, 64'd17);
    run_msg(64'd65, 0, 200, got, lat, done);
    chk("rst_mid_ct", encrypted_message, 0);
    chk("rst_mid_kl", key_loaded, 0);
    chk("rst_mid_kd", key_dropped, 0);
    chk("rst_mid_me", mod_err, 0);
    chk("rst_mid_rdy", msg_ready, 0);
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    pulses = 0;
    repeat (600) begin
      @(negedge clk);
      pulses = pulses + int'(msg_received_sig);
    end
    chk("rst_mid_pulse", 64'(pulses), 0);
    load_key(64'd3233, 64'd17);
    do_job("post_rst", 64'd65, 64'd3233, 64'd17, 64'd2790, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
